apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Parametrised APB master that turns single-beat commands from a local requester into APB3 transfers on a one-hot, multi-slave bus; GPIO, UART and future peripherals attach as slaves. It adds what the current protocol block lacks: generic slave count and data and address widths, per-slave address decode, PREADY wait states, PSLVERR propagation, a decode-error path and a wait-state timeout. It sits between the system command source and the peripheral slaves.

## Interface
- NUM_SLAVES, 2: number of APB slaves, 1..16.
- ADDR_WIDTH, 8: PADDR width; top SEL_BITS = max(1, clog2(NUM_SLAVES)) bits select the slave.
- DATA_WIDTH, 32: PWDATA/PRDATA width, a multiple of 8.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort, at least 1.

- PCLK  in  1  sole clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 on writes and errors.
- rsp_err  out  1  valid with rsp_valid: PSLVERR, decode error or timeout.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  transfer direction.
- PADDR  out  ADDR_WIDTH  registered address.
- PWDATA  out  DATA_WIDTH  registered write data.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.
- state  out  2  current FSM state, for debug.

## Operation
- States: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
- IDLE: cmd_ready=1. On cmd_valid, register addr, wdata and write, and decode idx = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS].
  - If idx < NUM_SLAVES, go to SETUP.
  - If idx >= NUM_SLAVES, stay in IDLE, start no bus activity, and pulse rsp_valid with rsp_err=1 on the next cycle.
- SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. The timeout counter counts up from 0.
  - PREADY[idx]=1: go to IDLE. Pulse rsp_valid next cycle with rsp_err=PSLVERR[idx]. rsp_rdata = PRDATA slice when the transfer is a read and PSLVERR is 0, else 0.
  - PREADY[idx]=0 with counter at TIMEOUT-1: abort to IDLE, drop PSEL and PENABLE, pulse rsp_valid with rsp_err=1.
- Only the selected slave's PREADY, PSLVERR and PRDATA are examined; all other slaves' inputs are ignored.
- PADDR, PWDATA and PWRITE hold stable from SETUP through the end of ACCESS. In IDLE they keep their last values.

## Timing
- Reset values: state=IDLE, cmd_ready=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- Command accepted at edge N: SETUP during N+1, ACCESS from N+2. With zero wait states, rsp_valid is high during N+3. Each wait state adds one cycle.
- Decode error accepted at edge N: rsp_valid=1 and rsp_err=1 during N+1.
- cmd_ready is high in the same cycle rsp_valid pulses, so a command can be accepted there. Peak throughput is one transfer per 3 cycles.
- A timeout aborts after exactly TIMEOUT ACCESS cycles.
- PRESET asserted mid-transfer forces the reset values immediately. No response is issued for the interrupted command.
- rsp_valid is one cycle wide; there is no back-pressure on responses.

## Structure
- Package apb_pkg holds the state localparams (ST_IDLE, ST_SETUP, ST_ACCESS) and the SEL_BITS helper function.
- Sub-module apb_slave_mux, purely combinational: takes idx and returns the selected PREADY, PSLVERR and PRDATA slice. It is parametrised on NUM_SLAVES and DATA_WIDTH.
- The FSM, timeout counter and response registers live in apb_master_bridge.

## Test plan
- Reset, then write 32'hF0F0F0F0 to addr 8'h01 on slave 0 with PREADY tied high. Expect PSEL=2'b01 in N+1, PENABLE in N+2, and rsp_valid with rsp_err=0 in N+3.
- Read addr 8'h81 on slave 1 with PRDATA slice 32'h00000AAA and PREADY delayed by 3 cycles. Expect ACCESS to last 4 cycles, rsp_rdata=32'h00000AAA, and PADDR stable throughout.
- Build with NUM_SLAVES=3, SEL_BITS=2 and read addr 8'hC0. Expect no PSEL activity, and rsp_valid with rsp_err=1 in N+1.
- Read with PSLVERR[1]=1 at ready. Expect rsp_err=1 and rsp_rdata=0.
- TIMEOUT=4 with PREADY held low. Expect an abort after 4 ACCESS cycles, rsp_err=1, and a following command accepted normally.
- Assert PRESET during ACCESS of a write. Expect all outputs at reset values asynchronously, and no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared state encoding and slave-select width helper for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  // Address bits used to pick a slave; a single-slave bus still spends one bit.
  function automatic int sel_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Combinational return-path mux: forwards only the addressed slave's PREADY, PSLVERR and PRDATA.
module apb_slave_mux #(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 1
) (
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [NUM_SLAVES-1:0]            i_pready,
  input  logic [NUM_SLAVES-1:0]            i_pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
  output logic                             o_pready,
  output logic                             o_pslverr,
  output logic [DATA_WIDTH-1:0]            o_prdata
);

  // An out-of-range index yields all zeros.
  always_comb begin
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    o_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(i_idx) == i) begin
        o_pready  = i_pready[i];
        o_pslverr = i_pslverr[i];
        o_prdata  = i_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master: single-beat local commands to a one-hot multi-slave bus, with decode-error and wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  output logic [1:0]                       state
);

  localparam int SEL_BITS = sel_bits(NUM_SLAVES);
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_BITS:0] NUM_SEL  = (SEL_BITS + 1)'(NUM_SLAVES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_BITS-1:0]   r_idx;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic [CNT_W-1:0]      r_tcnt;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_idx_ok;
  logic                  w_accept;
  logic                  w_dec_err;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_bus_active;
  logic                  w_sel_ready;
  logic                  w_sel_slverr;
  logic [DATA_WIDTH-1:0] w_sel_rdata;

  assign w_idx    = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_idx_ok = ({1'b0, w_idx} < NUM_SEL);

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (SEL_BITS)
  ) u_slave_mux (
    .i_idx     (r_idx),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .i_prdata  (PRDATA),
    .o_pready  (w_sel_ready),
    .o_pslverr (w_sel_slverr),
    .o_prdata  (w_sel_rdata)
  );

  // Next state and transfer-completion events
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dec_err   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (w_idx_ok) w_state_nxt = ST_SETUP;
          else          w_dec_err   = 1'b1;
        end
      end
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus-side request registers, held through SETUP and ACCESS
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_idx    <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (w_accept) begin
      r_idx    <= w_idx;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
      r_pwrite <= cmd_write;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tcnt <= '0;
    end else if ((r_state == ST_ACCESS) && (w_state_nxt == ST_ACCESS)) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  // Response stage: one-cycle pulse after completion, abort or decode error
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_dec_err | w_done | w_timeout;
      r_rsp_err   <= w_dec_err | w_timeout | (w_done & w_sel_slverr);
      r_rsp_rdata <= (w_done && !r_pwrite && !w_sel_slverr) ? w_sel_rdata : '0;
    end
  end

  assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = w_bus_active && (int'(r_idx) == i);
    end
  end

  assign PENABLE   = (r_state == ST_ACCESS);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign state     = r_state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table-driven and randomized transfers on a 2-slave bus, decode error on a 3-slave bus.
module tb_apb_master_bridge;

  localparam int TO_A = 4;

  logic        PCLK;
  logic        PRESET;

  // DUT A: two slaves, short timeout
  logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
  logic [7:0]  a_cmd_addr;
  logic [31:0] a_cmd_wdata;
  logic        a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_psel;
  logic        a_penable, a_pwrite;
  logic [7:0]  a_paddr;
  logic [31:0] a_pwdata;
  logic [63:0] a_prdata;
  logic [1:0]  a_pready, a_pslverr;
  logic [1:0]  a_state;

  // DUT B: three slaves, two select bits
  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [7:0]  b_cmd_addr;
  logic [31:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [2:0]  b_psel;
  logic        b_penable, b_pwrite;
  logic [7:0]  b_paddr;
  logic [31:0] b_pwdata;
  logic [95:0] b_prdata;
  logic [2:0]  b_pready, b_pslverr;
  logic [1:0]  b_state;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(.NUM_SLAVES(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(TO_A)) dut_a (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
    .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr), .state(a_state)
  );

  apb_master_bridge #(.NUM_SLAVES(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
    .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr), .state(b_state)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Selected slave gets the planned values; the other slave gets noise that must be ignored.
  task automatic drive_slaves(input int idx, input logic rdy, input logic err, input logic [31:0] rd);
    a_pready  = 2'($urandom);
    a_pslverr = 2'($urandom);
    a_prdata  = {$urandom, $urandom};
    a_pready[idx]           = rdy;
    a_pslverr[idx]          = err;
    a_prdata[idx*32 +: 32]  = rd;
  endtask

  // Starts just after a rising edge with DUT A idle; returns just after the edge ending the response cycle.
  task automatic run_txn(input string nm, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int waits, input logic err, input logic [31:0] rd,
                         input int exp_acc, input logic exp_err, input logic [31:0] exp_rd);
    int         idx;
    logic [1:0] oh;
    idx = int'(addr[7]);
    oh  = (idx == 1) ? 2'b10 : 2'b01;
    a_cmd_valid = 1'b1;
    a_cmd_write = wr;
    a_cmd_addr  = addr;
    a_cmd_wdata = wd;
    @(negedge PCLK);
    check({nm, " idle cmd_ready"}, a_cmd_ready, 1);
    check({nm, " idle rsp_valid"}, a_rsp_valid, 0);
    @(posedge PCLK); #1;
    a_cmd_valid = 1'b0;
    a_cmd_addr  = 8'($urandom);
    a_cmd_wdata = $urandom;
    @(negedge PCLK);
    check({nm, " setup state"}, a_state, 2'b01);
    check({nm, " setup psel"}, a_psel, oh);
    check({nm, " setup penable"}, a_penable, 0);
    check({nm, " setup cmd_ready"}, a_cmd_ready, 0);
    check({nm, " setup paddr"}, a_paddr, addr);
    check({nm, " setup pwrite"}, a_pwrite, wr);
    check({nm, " setup pwdata"}, a_pwdata, wd);
    for (int j = 0; j < exp_acc; j++) begin
      @(posedge PCLK); #1;
      drive_slaves(idx, (j >= waits), err, rd);
      @(negedge PCLK);
      check({nm, " access state"}, a_state, 2'b10);
      check({nm, " access psel"}, a_psel, oh);
      check({nm, " access penable"}, a_penable, 1);
      check({nm, " access paddr"}, a_paddr, addr);
      check({nm, " access pwdata"}, a_pwdata, wd);
      check({nm, " access rsp_valid"}, a_rsp_valid, 0);
    end
    @(posedge PCLK); #1;
    drive_slaves(idx, 1'b0, 1'b0, 32'h0);
    @(negedge PCLK);
    check({nm, " rsp_valid"}, a_rsp_valid, 1);
    check({nm, " rsp_err"}, a_rsp_err, exp_err);
    check({nm, " rsp_rdata"}, a_rsp_rdata, exp_rd);
    check({nm, " rsp state"}, a_state, 2'b00);
    check({nm, " rsp psel"}, a_psel, 0);
    check({nm, " rsp penable"}, a_penable, 0);
    check({nm, " rsp cmd_ready"}, a_cmd_ready, 1);
    @(posedge PCLK); #1;
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          waits;
    logic        err;
    logic [31:0] rd;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        r_wr, r_err, to;
    logic [7:0]  r_addr;
    logic [31:0] r_wd, r_rd, m_rd;
    int          r_waits, m_acc;

    vecs[0] = '{"wr_s0_nowait", 1'b1, 8'h01, 32'hF0F0F0F0, 0, 1'b0, 32'h0,        1, 1'b0, 32'h0};
    vecs[1] = '{"rd_s1_wait3",  1'b0, 8'h81, 32'h0,        3, 1'b0, 32'h00000AAA, 4, 1'b0, 32'h00000AAA};
    vecs[2] = '{"rd_s1_slverr", 1'b0, 8'h81, 32'h0,        0, 1'b1, 32'h12345678, 1, 1'b1, 32'h0};
    vecs[3] = '{"rd_s0_tmo",    1'b0, 8'h10, 32'h0,        4, 1'b0, 32'hCAFEF00D, 4, 1'b1, 32'h0};
    vecs[4] = '{"wr_s0_after",  1'b1, 8'h22, 32'h55AA55AA, 1, 1'b0, 32'h0,        2, 1'b0, 32'h0};
    vecs[5] = '{"wr_s0_slverr", 1'b1, 8'h7F, 32'hA5A5A5A5, 2, 1'b1, 32'h0,        3, 1'b1, 32'h0};
    vecs[6] = '{"wr_s1_tmo",    1'b1, 8'hFF, 32'h01020304, 9, 1'b0, 32'h0,        4, 1'b1, 32'h0};

    PRESET      = 1'b1;
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = '0; a_cmd_wdata = '0;
    a_prdata    = '0;   a_pready    = '0;   a_pslverr  = '0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
    b_prdata    = '0;   b_pready    = '0;   b_pslverr  = '0;

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("reset state", a_state, 2'b00);
    check("reset cmd_ready", a_cmd_ready, 1);
    check("reset psel", a_psel, 0);
    check("reset penable", a_penable, 0);
    check("reset pwrite", a_pwrite, 0);
    check("reset paddr", a_paddr, 0);
    check("reset pwdata", a_pwdata, 0);
    check("reset rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Decode error on the 3-slave bus: index 3 does not exist
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 8'hC0;
    @(posedge PCLK); #1;
    b_cmd_valid = 1'b0;
    @(negedge PCLK);
    check("decerr rsp_valid", b_rsp_valid, 1);
    check("decerr rsp_err", b_rsp_err, 1);
    check("decerr rsp_rdata", b_rsp_rdata, 0);
    check("decerr psel", b_psel, 0);
    check("decerr state", b_state, 2'b00);
    check("decerr cmd_ready", b_cmd_ready, 1);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("decerr pulse width", b_rsp_valid, 0);
    check("decerr psel after", b_psel, 0);
    // Slave 2 on the 3-slave bus, ready tied high
    @(posedge PCLK); #1;
    b_pready = 3'b111;
    b_prdata = {32'h5A5A0002, 32'h11110001, 32'h22220000};
    b_cmd_valid = 1'b1; b_cmd_addr = 8'h80;
    @(posedge PCLK); #1;
    b_cmd_valid = 1'b0;
    @(negedge PCLK);
    check("b s2 setup psel", b_psel, 3'b100);
    check("b s2 setup penable", b_penable, 0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("b s2 access penable", b_penable, 1);
    check("b s2 access rsp_valid", b_rsp_valid, 0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("b s2 rsp_valid", b_rsp_valid, 1);
    check("b s2 rsp_err", b_rsp_err, 0);
    check("b s2 rsp_rdata", b_rsp_rdata, 32'h5A5A0002);
    @(posedge PCLK); #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].nm, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits, vecs[i].err,
              vecs[i].rd, vecs[i].exp_acc, vecs[i].exp_err, vecs[i].exp_rd);
    end

    // Randomized transfers checked against the response rules
    for (int i = 0; i < 30; i++) begin
      r_wr    = 1'($urandom);
      r_err   = ($urandom_range(0, 3) == 0);
      r_addr  = 8'($urandom);
      r_wd    = $urandom;
      r_rd    = $urandom;
      r_waits = int'($urandom_range(0, 6));
      to      = (r_waits >= TO_A);
      m_acc   = to ? TO_A : r_waits + 1;
      m_rd    = (!to && !r_err && !r_wr) ? r_rd : 32'h0;
      run_txn("rand", r_wr, r_addr, r_wd, r_waits, r_err, r_rd, m_acc, to | r_err, m_rd);
    end

    // Reset in the middle of an ACCESS phase
    a_pready    = 2'b00;
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 8'h01; a_cmd_wdata = 32'h11223344;
    @(posedge PCLK); #1;
    a_cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("midrst in access", a_state, 2'b10);
    #2;
    PRESET = 1'b1;
    #1;
    check("midrst state", a_state, 2'b00);
    check("midrst psel", a_psel, 0);
    check("midrst penable", a_penable, 0);
    check("midrst pwrite", a_pwrite, 0);
    check("midrst paddr", a_paddr, 0);
    check("midrst pwdata", a_pwdata, 0);
    check("midrst cmd_ready", a_cmd_ready, 1);
    check("midrst rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK);
      check("midrst no rsp", a_rsp_valid, 0);
      check("midrst stays idle", a_state, 2'b00);
    end
    @(posedge PCLK); #1;
    run_txn("after_reset", 1'b0, 8'h84, 32'h0, 1, 1'b0, 32'h0BADF00D, 2, 1'b0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
